// File: rtl/folding_2_ctrl_if.sv
// Sample/config bus between the host/sample source and folding_2_ctrl.
//   x_in     : input sample from the source
//   x_valid  : x_in is valid
//   x_ready  : controller accepts a sample this cycle
//   cfg_we   : coefficient write strobe
//   cfg_sel  : 0 selects a, 1 selects b
//   cfg_data : coefficient value
// master = source/host side, slave = controller side.
interface folding_2_ctrl_if #(
  parameter int n = 16
);
  logic [n-1:0] x_in;
  logic         x_valid;
  logic         x_ready;
  logic         cfg_we;
  logic         cfg_sel;
  logic [n-1:0] cfg_data;

  modport master (
    output x_in, x_valid, cfg_we, cfg_sel, cfg_data,
    input  x_ready
  );

  modport slave (
    input  x_in, x_valid, cfg_we, cfg_sel, cfg_data,
    output x_ready
  );
endinterface

// File: rtl/folding_2_ctrl.sv
// Sequencer for the 2-folded IIR datapath Y[n] = a*Y[n-3] + b*Y[n-5] + X[n].
// Produces the fold phase (switch) and the datapath advance enable (dp_en),
// accepts input samples, holds the coefficient registers, qualifies output
// samples (y_valid) and runs a zero-fill flush after stop.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-low reset
//   start, stop  : single-cycle control pulses
//   bus          : sample handshake and coefficient write bus (slave side)
//   x_out        : registered sample fed to the datapath
//   coef_a/b     : registered coefficients
//   switch       : fold phase (0 = P0, 1 = P1)
//   dp_en        : datapath advance enable
//   y_valid      : datapath output is valid this cycle
//   cfg_err      : pulse when a coefficient write is rejected
//   busy         : controller is not idle
//   sample_cnt   : saturating count of accepted samples
module folding_2_ctrl #(
  parameter int n         = 16,
  parameter int WARMUP    = 5,
  parameter int FLUSH_LEN = 5,
  parameter int CW        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  folding_2_ctrl_if.slave     bus,
  output logic [n-1:0]        x_out,
  output logic [n-1:0]        coef_a,
  output logic [n-1:0]        coef_b,
  output logic                switch,
  output logic                dp_en,
  output logic                y_valid,
  output logic                cfg_err,
  output logic                busy,
  output logic [CW-1:0]       sample_cnt
);

  localparam int FCW = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN);

  typedef enum logic [2:0] {
    IDLE,
    RUN_P0,
    RUN_P1,
    FLUSH_P0,
    FLUSH_P1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           stop_pend;
  logic [FCW-1:0] flush_cnt;
  logic           x_ready;
  logic           enter_flush;
  logic           accept;
  logic           flush_done;

  assign bus.x_ready = x_ready;
  assign busy        = (state != IDLE);
  assign accept      = (state == RUN_P0) && bus.x_valid;
  assign flush_done  = (flush_cnt == FCW'(FLUSH_LEN - 1));
  // A stop seen in this RUN_P1 cycle counts the same as an earlier pending one.
  assign enter_flush = (state == RUN_P1) && (stop_pend || stop);

  // Next-state and phase decode. Outputs depend on state only, except dp_en in
  // RUN_P0 which follows x_valid so a stalled P0 freezes the datapath.
  always_comb begin
    state_nxt = state;
    switch    = 1'b0;
    dp_en     = 1'b0;
    x_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN_P0;
      end
      RUN_P0: begin
        x_ready = 1'b1;
        dp_en   = bus.x_valid;
        if (bus.x_valid) state_nxt = RUN_P1;
      end
      RUN_P1: begin
        switch    = 1'b1;
        dp_en     = 1'b1;
        state_nxt = enter_flush ? FLUSH_P0 : RUN_P0;
      end
      FLUSH_P0: begin
        dp_en     = 1'b1;
        state_nxt = FLUSH_P1;
      end
      FLUSH_P1: begin
        switch    = 1'b1;
        dp_en     = 1'b1;
        state_nxt = flush_done ? IDLE : FLUSH_P0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus all registered outputs. Coefficients only change in
  // IDLE, so they are constant across a whole run; late writes flag cfg_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      stop_pend  <= 1'b0;
      flush_cnt  <= '0;
      x_out      <= '0;
      coef_a     <= '0;
      coef_b     <= '0;
      y_valid    <= 1'b0;
      cfg_err    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (bus.cfg_we && (state == IDLE)) begin
        if (bus.cfg_sel) coef_b <= bus.cfg_data;
        else             coef_a <= bus.cfg_data;
      end
      cfg_err <= bus.cfg_we && (state != IDLE);

      if (enter_flush) begin
        stop_pend <= 1'b0;
      end else if (stop && ((state == RUN_P0) || (state == RUN_P1))) begin
        stop_pend <= 1'b1;
      end

      if ((state == IDLE) && start) begin
        sample_cnt <= '0;
      end else if (accept && (sample_cnt != '1)) begin
        sample_cnt <= sample_cnt + 1'b1;
      end

      if (accept) begin
        x_out <= bus.x_in;
      end else if (enter_flush) begin
        x_out <= '0;
      end

      if (state == FLUSH_P1) begin
        flush_cnt <= flush_done ? '0 : flush_cnt + 1'b1;
      end

      // The datapath output settles one cycle after each P1 step.
      y_valid <= ((state == RUN_P1) || (state == FLUSH_P1)) &&
                 (sample_cnt >= CW'(WARMUP));
    end
  end

endmodule

// File: tb/tb_folding_2_ctrl.sv
// Self-checking bench for folding_2_ctrl. Directed stimulus drives the bus
// interface; expected y_valid events are queued and a monitor compares them
// against the DUT whenever y_valid is presented.
module tb_folding_2_ctrl;

  localparam int N      = 16;
  localparam int WARMUP = 5;
  localparam int FLEN   = 5;
  localparam int TB_CW  = 4;
  localparam int CMAX   = (1 << TB_CW) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [N-1:0]     x_out;
  logic [N-1:0]     coef_a;
  logic [N-1:0]     coef_b;
  logic             switch;
  logic             dp_en;
  logic             y_valid;
  logic             cfg_err;
  logic             busy;
  logic [TB_CW-1:0] sample_cnt;

  folding_2_ctrl_if #(.n(N)) bus_if ();

  folding_2_ctrl #(
    .n(N), .WARMUP(WARMUP), .FLUSH_LEN(FLEN), .CW(TB_CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus_if),
    .x_out(x_out), .coef_a(coef_a), .coef_b(coef_b), .switch(switch),
    .dp_en(dp_en), .y_valid(y_valid), .cfg_err(cfg_err), .busy(busy),
    .sample_cnt(sample_cnt)
  );

  typedef struct {
    int cnt;
    int a;
    int b;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   m_cnt      = 0;
  int   m_a        = 0;
  int   m_b        = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic xv, input logic [N-1:0] xi,
                               input logic st, input logic sp, input logic we,
                               input logic sel, input logic [N-1:0] d);
    bus_if.x_valid  = xv;
    bus_if.x_in     = xi;
    start           = st;
    stop            = sp;
    bus_if.cfg_we   = we;
    bus_if.cfg_sel  = sel;
    bus_if.cfg_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect();
    exp_t e;
    if (m_cnt >= WARMUP) begin
      e.cnt = m_cnt;
      e.a   = m_a;
      e.b   = m_b;
      exp_q.push_back(e);
    end
  endtask

  // One full P0/P1 pair starting from RUN_P0; returns in the following P0.
  task automatic feed_sample(input logic [N-1:0] v, input logic stop_p0,
                             input logic stop_p1);
    applyStimulus(1'b1, v, 1'b0, stop_p0, 1'b0, 1'b0, '0);
    checkOutput("p0_dp_en", dp_en, 1);
    checkOutput("p0_x_ready", bus_if.x_ready, 1);
    checkOutput("p0_switch", switch, 0);
    tick();
    m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    applyStimulus(1'b0, '0, 1'b0, stop_p1, 1'b0, 1'b0, '0);
    checkOutput("p1_switch", switch, 1);
    checkOutput("p1_dp_en", dp_en, 1);
    checkOutput("p1_x_ready", bus_if.x_ready, 0);
    checkOutput("p1_x_out", x_out, v);
    checkOutput("p1_sample_cnt", sample_cnt, m_cnt);
    push_expect();
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Starts in FLUSH_P0; walks all flush pairs and checks the return to IDLE.
  task automatic run_flush();
    for (int f = 0; f < FLEN; f++) push_expect();
    for (int f = 0; f < FLEN; f++) begin
      checkOutput("fl0_dp_en", dp_en, 1);
      checkOutput("fl0_switch", switch, 0);
      checkOutput("fl0_x_ready", bus_if.x_ready, 0);
      checkOutput("fl0_x_out", x_out, 0);
      checkOutput("fl0_busy", busy, 1);
      tick();
      checkOutput("fl1_dp_en", dp_en, 1);
      checkOutput("fl1_switch", switch, 1);
      checkOutput("fl1_x_out", x_out, 0);
      checkOutput("fl1_sample_cnt", sample_cnt, m_cnt);
      tick();
    end
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_dp_en", dp_en, 0);
    checkOutput("idle_switch", switch, 0);
  endtask

  // Scoreboard monitor: each presented y_valid consumes one expected entry.
  always @(negedge clk) begin
    if (rst && y_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("y_valid_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("yv_sample_cnt", sample_cnt, e.cnt);
        checkOutput("yv_coef_a", coef_a, e.a);
        checkOutput("yv_coef_b", coef_b, e.b);
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_x_ready", bus_if.x_ready, 0);
    checkOutput("rst_dp_en", dp_en, 0);
    checkOutput("rst_switch", switch, 0);
    checkOutput("rst_y_valid", y_valid, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_x_out", x_out, 0);
    checkOutput("rst_coefs", {coef_a, coef_b}, 0);
    checkOutput("rst_sample_cnt", sample_cnt, 0);
    rst = 1'b1;
    tick();

    // Write a in IDLE, then write b together with start.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    m_a = 2; m_b = 3; m_cnt = 0;
    checkOutput("cfg_coef_a", coef_a, 2);
    checkOutput("cfg_coef_b", coef_b, 3);
    checkOutput("cfg_no_err", cfg_err, 0);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_cnt", sample_cnt, 0);
    checkOutput("start_dp_en_idle_p0", dp_en, 0);

    // Eight back-to-back samples with a 3-cycle stall after the fourth.
    for (int i = 1; i <= 8; i++) begin
      feed_sample(16'h1000 + 16'(i), 1'b0, 1'b0);
      if (i == 4) begin
        for (int s = 0; s < 3; s++) begin
          checkOutput("stall_dp_en", dp_en, 0);
          checkOutput("stall_switch", switch, 0);
          checkOutput("stall_x_ready", bus_if.x_ready, 1);
          checkOutput("stall_cnt", sample_cnt, 4);
          checkOutput("stall_x_out", x_out, 16'h1004);
          tick();
        end
      end
    end
    checkOutput("run_cnt8", sample_cnt, 8);

    // Coefficient write while busy is rejected.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("busy_cfg_err", cfg_err, 1);
    checkOutput("busy_coef_a", coef_a, 2);
    checkOutput("busy_still_p0", bus_if.x_ready, 1);
    tick();
    checkOutput("busy_cfg_err_clear", cfg_err, 0);

    // Stop during RUN_P1 finishes the pair, then flushes.
    feed_sample(16'h1009, 1'b0, 1'b1);
    run_flush();

    // Asynchronous reset in the middle of a run.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    m_cnt = 0;
    feed_sample(16'h2001, 1'b0, 1'b0);
    feed_sample(16'h2002, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    m_a = 0; m_b = 0; m_cnt = 0;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_x_ready", bus_if.x_ready, 0);
    checkOutput("arst_x_out", x_out, 0);
    checkOutput("arst_coef_a", coef_a, 0);
    checkOutput("arst_coef_b", coef_b, 0);
    checkOutput("arst_cnt", sample_cnt, 0);
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_cnt", sample_cnt, 0);

    // Run past the counter limit; last sample carries stop in RUN_P0.
    for (int k = 1; k <= 17; k++) begin
      feed_sample(16'hA000 + 16'(k), (k == 17), 1'b0);
    end
    checkOutput("sat_cnt", sample_cnt, CMAX);
    run_flush();

    repeat (3) tick();
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
